// File: rtl/div_32bits_seq_pkg.sv
// -----------------------------------------------------------------------------
// foc_div_pkg
// Shared definitions for the sequential signed 32/32 divider (div_32bits_seq).
// Contents:
//   div_state_e    : controller states IDLE, CALC, FIX, DONE
//   DIV_W / CNT_W  : datapath width and iteration counter width
//   Q_POS_SAT / Q_NEG_SAT : quotient saturation limits (used with DIV32_SAT_EN)
//   mag()          : two's-complement magnitude; 0x80000000 maps to itself,
//                    which is the correct unsigned magnitude.
// -----------------------------------------------------------------------------
package foc_div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;

  localparam logic [DIV_W-1:0] Q_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [DIV_W-1:0] Q_NEG_SAT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x);
    return x[DIV_W-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_32bits_seq_if.sv
// -----------------------------------------------------------------------------
// div_32bits_seq_if
// Handshake bundle for div_32bits_seq.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_zero)
// Modports:
//   master : the operand producer / result consumer
//   slave  : the divider
// -----------------------------------------------------------------------------
interface div_32bits_seq_if;
  import foc_div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_32bits_seq_step.sv
// -----------------------------------------------------------------------------
// div32_step
// One combinational restoring-division iteration over unsigned magnitudes.
// Ports:
//   rem_i  [32:0] : partial remainder before this step
//   q_i    [31:0] : quotient shift register (dividend bits shift out of MSB,
//                   quotient bits shift in at LSB)
//   d_i    [31:0] : divisor magnitude
//   rem_o  [32:0] : partial remainder after this step
//   q_o    [31:0] : quotient shift register after this step
// -----------------------------------------------------------------------------
module div32_step
  import foc_div_pkg::*;
(
  input  logic [DIV_W:0]   rem_i,
  input  logic [DIV_W-1:0] q_i,
  input  logic [DIV_W-1:0] d_i,
  output logic [DIV_W:0]   rem_o,
  output logic [DIV_W-1:0] q_o
);

  logic [DIV_W:0] r_shift;
  logic [DIV_W:0] d_ext;

  always_comb begin
    r_shift = {rem_i[DIV_W-1:0], q_i[DIV_W-1]};
    d_ext   = {1'b0, d_i};
    if (r_shift >= d_ext) begin
      rem_o = r_shift - d_ext;
      q_o   = {q_i[DIV_W-2:0], 1'b1};
    end else begin
      rem_o = r_shift;
      q_o   = {q_i[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32bits_seq.sv
// -----------------------------------------------------------------------------
// div_32bits_seq
// Sequential signed 32/32 divider: radix-2 restoring division over magnitudes,
// one quotient bit per clock, followed by sign correction.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : div_32bits_seq_if.slave (operand and result handshakes)
// Build option:
//   DIV32_SAT_EN defined   -> divide-by-zero and 0x80000000/-1 saturate
//   DIV32_SAT_EN undefined -> divide-by-zero gives q=-1, r=dividend; overflow wraps
// -----------------------------------------------------------------------------
module div_32bits_seq
  import foc_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  div_32bits_seq_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   rem_q, rem_d;
  logic [DIV_W-1:0] qsh_q, qsh_d;
  logic [DIV_W-1:0] dmag_q, dmag_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             dz_q, dz_d;
  logic [DIV_W-1:0] quotient_q, quotient_d;
  logic [DIV_W-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             out_valid_q, out_valid_d;

  logic [DIV_W:0]   step_rem;
  logic [DIV_W-1:0] step_q;
  logic [DIV_W-1:0] q_signed;
  logic [DIV_W-1:0] r_signed;
  logic [DIV_W-1:0] q_fix;
  logic [DIV_W-1:0] r_fix;

  div32_step u_step (
    .rem_i (rem_q),
    .q_i   (qsh_q),
    .d_i   (dmag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Sign correction and the special-case rules. For a zero divisor no
  // iterations run, so qsh_q still holds |dividend| and is used to rebuild
  // the original dividend.
  always_comb begin
    q_signed = sign_quo_q ? (~qsh_q + 32'd1) : qsh_q;
    r_signed = sign_rem_q ? (~rem_q[DIV_W-1:0] + 32'd1) : rem_q[DIV_W-1:0];
    q_fix    = q_signed;
    r_fix    = r_signed;
`ifdef DIV32_SAT_EN
    if (dz_q) begin
      q_fix = sign_rem_q ? Q_NEG_SAT : Q_POS_SAT;
      r_fix = '0;
    end else if (!sign_quo_q && qsh_q[DIV_W-1]) begin
      // Only -2^31 / -1 yields a positive magnitude of 2^31.
      q_fix = Q_POS_SAT;
    end
`else
    if (dz_q) begin
      q_fix = '1;
      r_fix = sign_rem_q ? (~qsh_q + 32'd1) : qsh_q;
    end
`endif
  end

  // Controller: operand capture, 32 iterations, sign fix, result hold.
  // A zero divisor spends one CALC cycle without iterating before FIX.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    qsh_d       = qsh_q;
    dmag_d      = dmag_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dmag_d     = mag(bus.divisor);
          qsh_d      = mag(bus.dividend);
          rem_d      = '0;
          cnt_d      = '0;
          sign_quo_d = bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1];
          sign_rem_d = bus.dividend[DIV_W-1];
          dz_d       = (bus.divisor == '0);
          state_d    = CALC;
        end
      end
      CALC: begin
        if (dz_q) begin
          state_d = FIX;
        end else begin
          rem_d = step_rem;
          qsh_d = step_q;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CNT_W'(DIV_W-1)) state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = q_fix;
        remainder_d = r_fix;
        div_zero_d  = dz_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qsh_q       <= '0;
      dmag_q      <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      qsh_q       <= qsh_d;
      dmag_q      <= dmag_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_32bits_seq.sv
// -----------------------------------------------------------------------------
// tb_div_32bits_seq
// Directed bench for div_32bits_seq. Expected results come from an integer
// arithmetic model; a negedge compare process checks held results and the
// in_ready/out_valid exclusion every cycle. Honours DIV32_SAT_EN.
// -----------------------------------------------------------------------------
module tb_div_32bits_seq;

  logic clk;
  logic rst_n;

  div_32bits_seq_if bus ();

  div_32bits_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks;
  int n_fail;

  logic [31:0] exp_q;
  logic [31:0] exp_r;
  logic        exp_dz;
  logic        exp_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper used by every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  // Reference model: plain signed integer division plus the edge-case rules.
  task automatic model(input int a, input int b, output logic [31:0] q,
                       output logic [31:0] r, output logic dz);
    dz = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
`ifdef DIV32_SAT_EN
      q = (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r = 32'h0;
`else
      q = 32'hFFFF_FFFF;
      r = a;
`endif
    end else if (a == 32'sh8000_0000 && b == -1) begin
`ifdef DIV32_SAT_EN
      q = 32'h7FFF_FFFF;
`else
      q = 32'h8000_0000;
`endif
      r = 32'h0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Compare process: whenever a result is held it must match the model,
  // and in_ready/out_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rdy_vld_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
      if (exp_valid && bus.out_valid) begin
        checkOutput("model_q", bus.quotient, exp_q);
        checkOutput("model_r", bus.remainder, exp_r);
        checkOutput("model_dz", 32'(bus.div_zero), 32'(exp_dz));
      end
    end
  end

  // One full transaction: accept, measure latency, optional backpressure,
  // then check literal results and the handshake return to IDLE.
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] lit_q,
                               input logic [31:0] lit_r, input logic lit_dz,
                               input int exp_lat, input int hold);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    model(a, b, exp_q, exp_r, exp_dz);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_q"}, bus.quotient, lit_q);
    checkOutput({name, "_r"}, bus.remainder, lit_r);
    checkOutput({name, "_dz"}, 32'(bus.div_zero), 32'(lit_dz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({name, "_bp_q"}, bus.quotient, lit_q);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_valid = 1'b0;
    checkOutput({name, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_in_ready_ret"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_valid     = 1'b0;
    exp_q         = '0;
    exp_r         = '0;
    exp_dz        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_q", bus.quotient, 32'd0);
    checkOutput("rst_r", bus.remainder, 32'd0);
    checkOutput("rst_dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
    applyStimulus("n100_p7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 33, 0);
    applyStimulus("p100_n7", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 33, 0);
    applyStimulus("n100_n7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33, 0);
`ifdef DIV32_SAT_EN
    applyStimulus("p5_zero", 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd0, 1'b1, 2, 0);
    applyStimulus("n5_zero", -32'sd5, 32'd0, 32'h8000_0000, 32'd0, 1'b1, 2, 0);
    applyStimulus("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 33, 0);
`else
    applyStimulus("p5_zero", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);
    applyStimulus("n5_zero", -32'sd5, 32'd0, 32'hFFFF_FFFF, -32'sd5, 1'b1, 2, 0);
    applyStimulus("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
`endif
    applyStimulus("min_p1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    applyStimulus("zero_p5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 0);
    applyStimulus("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 33, 0);
    applyStimulus("big_1000", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 33, 0);
    applyStimulus("neg1_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33, 0);
    applyStimulus("bp_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 10);

    // Reset in the middle of CALC: result must be lost, outputs back to reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd12345;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_q", bus.quotient, 32'd0);
    checkOutput("midrst_r", bus.remainder, 32'd0);
    checkOutput("midrst_dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midrst_lost", 32'(bus.out_valid), 32'd0);
    applyStimulus("after_rst", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
